// File: rtl/mem_stage_mq.sv
// In-order memory stage queue tracking outstanding data-SRAM requests between EX and WB.
// Optional MS_RDATA_BYPASS_EN forwards returning head data to WB in the response cycle.
module mem_stage_mq #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [31:0]       es_pc,
  input  logic [DATA_W-1:0] es_alu_result,
  input  logic              es_gr_we,
  input  logic [4:0]        es_dest,
  input  logic              es_mem_req,
  input  logic              es_load_op,
  input  logic [1:0]        es_ld_size,
  input  logic              es_ld_sign,
  input  logic              es_ex,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [31:0]       ms_pc,
  output logic              ms_gr_we,
  output logic [4:0]        ms_dest,
  output logic              ms_ex,
  output logic [DATA_W-1:0] ms_final_result,
  input  logic              ms_flush,
  output logic [31:0]       ms_load_pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DATA_W / 8);
  localparam int CW = AW + 1;
  localparam int DW = AW + 2;

  logic [DEPTH-1:0] vld_q, vld_d, wait_q, wait_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d, rsp_q, rsp_d;
  logic [CW-1:0]    count_q, count_d, nwait;
  logic [DW-1:0]    drop_q, drop_d;

  logic [31:0]       pc_q   [DEPTH];
  logic [OW-1:0]     off_q  [DEPTH];
  logic [1:0]        size_q [DEPTH];
  logic              sign_q [DEPTH];
  logic [4:0]        dest_q [DEPTH];
  logic              gr_we_q[DEPTH];
  logic              ex_q   [DEPTH];
  logic              load_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic              enq, retire, capture, head_done, byp_hit, found;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] head_data;
  logic [31:0]       pend;

  function automatic logic [DATA_W-1:0] ld_extract(input logic [DATA_W-1:0] rd,
                                                   input logic [OW-1:0] off,
                                                   input logic [1:0] sz,
                                                   input logic sgn);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic              msb;
    sh = rd >> {off, 3'b000};
    case (sz)
      2'd0:    begin mask = DATA_W'(64'h0000_0000_0000_00FF); msb = sh[7];  end
      2'd1:    begin mask = DATA_W'(64'h0000_0000_0000_FFFF); msb = sh[15]; end
      2'd2:    begin mask = DATA_W'(64'h0000_0000_FFFF_FFFF); msb = sh[31]; end
      default: begin mask = '1;                                msb = 1'b0;   end
    endcase
    return (sgn && msb) ? (sh | ~mask) : (sh & mask);
  endfunction

  assign ms_allowin = resetn && (count_q < CW'(DEPTH)) && !ms_flush;
  assign enq        = es_to_ms_valid && ms_allowin;
  // rsp_q always names the oldest waiting entry, so a set wait bit there means a response is owed.
  assign capture    = data_sram_data_ok && (drop_q == '0) && wait_q[rsp_q] && !ms_flush;
  assign head_done  = vld_q[head_q] && !wait_q[head_q];

`ifdef MS_RDATA_BYPASS_EN
  assign byp_hit = capture && (rsp_q == head_q) && vld_q[head_q];
`else
  assign byp_hit = 1'b0;
`endif

  assign ms_to_ws_valid = !ms_flush && (head_done || byp_hit);
  assign retire         = ms_to_ws_valid && ws_allowin;

  assign head_data = (byp_hit && load_q[head_q])
                   ? ld_extract(data_sram_rdata, off_q[head_q], size_q[head_q], sign_q[head_q])
                   : data_q[head_q];

  assign ms_pc           = ms_to_ws_valid ? pc_q[head_q]    : '0;
  assign ms_gr_we        = ms_to_ws_valid ? gr_we_q[head_q] : 1'b0;
  assign ms_dest         = ms_to_ws_valid ? dest_q[head_q]  : '0;
  assign ms_ex           = ms_to_ws_valid ? ex_q[head_q]    : 1'b0;
  assign ms_final_result = ms_to_ws_valid ? head_data       : '0;

  always_comb begin
    nwait = '0;
    pend  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nwait = nwait + CW'(wait_q[i]);
      if (vld_q[i] && wait_q[i] && gr_we_q[i]) pend[dest_q[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end
  assign ms_load_pending = pend;

  always_comb begin
    vld_d   = vld_q;
    wait_d  = wait_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    rsp_d   = rsp_q;
    found   = 1'b0;
    idx     = '0;
    if (ms_flush) begin
      vld_d   = '0;
      wait_d  = '0;
      head_d  = tail_q;
      count_d = '0;
      // Every response still owed to a discarded entry must be swallowed later.
      if (data_sram_data_ok && ((drop_q != '0) || (nwait != '0)))
        drop_d = drop_q + DW'(nwait) - DW'(1);
      else
        drop_d = drop_q + DW'(nwait);
    end else begin
      if (data_sram_data_ok && (drop_q != '0)) drop_d = drop_q - DW'(1);
      if (capture) wait_d[rsp_q] = 1'b0;
      if (retire) begin
        vld_d[head_q]  = 1'b0;
        wait_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
      end
      if (enq) begin
        vld_d[tail_q]  = 1'b1;
        wait_d[tail_q] = es_mem_req && !es_ex;
        tail_d         = tail_q + 1'b1;
      end
      count_d = count_q + CW'(enq) - CW'(retire);
    end
    rsp_d = tail_d;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_d + AW'(i);
      if (!found && wait_d[idx]) begin
        rsp_d = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q   <= '0;
      wait_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      rsp_q   <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      wait_q  <= wait_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rsp_q   <= rsp_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_q[tail_q]    <= es_pc;
      off_q[tail_q]   <= es_alu_result[OW-1:0];
      size_q[tail_q]  <= es_ld_size;
      sign_q[tail_q]  <= es_ld_sign;
      dest_q[tail_q]  <= es_dest;
      gr_we_q[tail_q] <= es_gr_we;
      ex_q[tail_q]    <= es_ex;
      load_q[tail_q]  <= es_load_op && es_mem_req && !es_ex;
      data_q[tail_q]  <= es_alu_result;
    end
    if (capture && load_q[rsp_q])
      data_q[rsp_q] <= ld_extract(data_sram_rdata, off_q[rsp_q], size_q[rsp_q], sign_q[rsp_q]);
  end

endmodule

// File: tb/tb_mem_stage_mq.sv
// Scoreboard bench for mem_stage_mq: directed stimulus pushes expected retirements, a monitor pops them.
module tb_mem_stage_mq;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              es_to_ms_valid, ms_allowin;
  logic [31:0]       es_pc;
  logic [DATA_W-1:0] es_alu_result;
  logic              es_gr_we;
  logic [4:0]        es_dest;
  logic              es_mem_req, es_load_op, es_ld_sign, es_ex;
  logic [1:0]        es_ld_size;
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              ws_allowin, ms_to_ws_valid;
  logic [31:0]       ms_pc;
  logic              ms_gr_we, ms_ex;
  logic [4:0]        ms_dest;
  logic [DATA_W-1:0] ms_final_result;
  logic              ms_flush;
  logic [31:0]       ms_load_pending;

  typedef struct {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic        ex;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   owed = 0;

  mem_stage_mq #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_alu_result(es_alu_result), .es_gr_we(es_gr_we), .es_dest(es_dest),
    .es_mem_req(es_mem_req), .es_load_op(es_load_op), .es_ld_size(es_ld_size),
    .es_ld_sign(es_ld_sign), .es_ex(es_ex), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_ex(ms_ex),
    .ms_final_result(ms_final_result), .ms_flush(ms_flush), .ms_load_pending(ms_load_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MS_RDATA_BYPASS_EN
  localparam int LD_LAT = 0;
`else
  localparam int LD_LAT = 1;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [4:0] dest, input logic ex,
                          input logic [31:0] res, input int c);
    exp_t e;
    e.pc = pc; e.gr_we = (dest != 5'd0); e.dest = dest; e.ex = ex; e.res = res; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic enq(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                     input logic mem, input logic ld, input logic [1:0] sz, input logic sg,
                     input logic ex);
    int n;
    es_pc = pc; es_alu_result = res; es_gr_we = (dest != 5'd0); es_dest = dest;
    es_mem_req = mem; es_load_op = ld; es_ld_size = sz; es_ld_sign = sg; es_ex = ex;
    es_to_ms_valid = 1'b1;
    n = 0;
    while (!ms_allowin && n < 50) begin
      tick();
      n++;
    end
    if (!ms_allowin) begin
      checks++;
      errors++;
      $display("FAIL enq_timeout: pc %0h never accepted", pc);
    end
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] rd);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic rsp_dropped(input logic [31:0] rd, input string name);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    #1;
    chk({name, "_same_cycle"}, 64'(ms_to_ws_valid), 64'd0);
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    chk({name, "_next_cycle"}, 64'(ms_to_ws_valid), 64'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        owed = 0;
      end else begin
        if (es_to_ms_valid && ms_allowin && es_mem_req && !es_ex) owed++;
        if (data_sram_data_ok) begin
          checks++;
          if (owed == 0) begin
            errors++;
            $display("FAIL stray_data_ok: response with %0d owed, required at least 1", owed);
          end else begin
            owed--;
          end
        end
        if (ms_to_ws_valid && ws_allowin) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_retire: pc %0h result %0h with empty scoreboard", ms_pc, ms_final_result);
          end else begin
            e = sb.pop_front();
            if ({ms_pc, ms_gr_we, ms_dest, ms_ex, ms_final_result} !== {e.pc, e.gr_we, e.dest, e.ex, e.res}) begin
              errors++;
              $display("FAIL retire_fields: got pc=%0h we=%0b dest=%0d ex=%0b res=%0h expected pc=%0h we=%0b dest=%0d ex=%0b res=%0h",
                       ms_pc, ms_gr_we, ms_dest, ms_ex, ms_final_result, e.pc, e.gr_we, e.dest, e.ex, e.res);
            end
            if (e.cyc >= 0) chk("retire_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  endtask

  initial begin
    int t;
    int n;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    resetn = 1'b0; es_to_ms_valid = 1'b0; es_pc = '0; es_alu_result = '0; es_gr_we = 1'b0;
    es_dest = '0; es_mem_req = 1'b0; es_load_op = 1'b0; es_ld_size = '0; es_ld_sign = 1'b0;
    es_ex = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_allowin = 1'b1; ms_flush = 1'b0;

    // Reset state
    #2;
    chk("rst_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("rst_allowin", 64'(ms_allowin), 64'd0);
    chk("rst_pending", 64'(ms_load_pending), 64'd0);
    chk("rst_result", 64'(ms_final_result), 64'd0);
    tick(); tick();
    resetn = 1'b1;
    #1;
    chk("post_rst_allowin", 64'(ms_allowin), 64'd1);

    // Non-memory instruction, presented the next cycle
    push_exp(32'h1c00_0000, 5'd3, 1'b0, 32'h1234_5678, cyc + 1);
    enq(32'h1c00_0000, 32'h1234_5678, 5'd3, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    chk("nonmem_pending", 64'(ms_load_pending), 64'd0);
    tick();

    // Four outstanding loads fill the queue
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h1c00_0010 + 32'(4 * i), 5'(5 + i), 1'b0, 32'hA000_0000 | 32'(5 + i), -1);
      enq(32'h1c00_0010 + 32'(4 * i), 32'h0000_1000 + 32'(4 * i), 5'(5 + i), 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    end
    chk("full_allowin", 64'(ms_allowin), 64'd0);
    chk("full_pending", 64'(ms_load_pending), 64'h1E0);
    chk("full_valid", 64'(ms_to_ws_valid), 64'd0);
    for (int i = 0; i < 4; i++) rsp(32'hA000_0000 | 32'(5 + i));
    tick(); tick();
    chk("drained_allowin", 64'(ms_allowin), 64'd1);
    chk("drained_pending", 64'(ms_load_pending), 64'd0);

    // Extraction: signed byte at offset 3, unsigned half at offset 2, store, exception
    push_exp(32'h1c00_0200, 5'd14, 1'b0, 32'hFFFF_FF80, -1);
    enq(32'h1c00_0200, 32'h0000_2003, 5'd14, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    rsp(32'h80FF_0000);
    enq(32'h1c00_0204, 32'h0000_2002, 5'd15, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    t = cyc;
    push_exp(32'h1c00_0204, 5'd15, 1'b0, 32'h0000_80FF, t + LD_LAT);
    rsp(32'h80FF_0000);
    push_exp(32'h1c00_0208, 5'd0, 1'b0, 32'h0000_3000, -1);
    enq(32'h1c00_0208, 32'h0000_3000, 5'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    rsp(32'hFFFF_FFFF);
    push_exp(32'h1c00_020c, 5'd4, 1'b1, 32'hBADC_0DE0, -1);
    enq(32'h1c00_020c, 32'hBADC_0DE0, 5'd4, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1);
    tick(); tick(); tick();

    // Flush with three loads outstanding and a response in the same cycle
    for (int i = 0; i < 3; i++)
      enq(32'h1c00_0300 + 32'(4 * i), 32'h0000_3000 + 32'(4 * i), 5'(10 + i), 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    chk("preflush_pending", 64'(ms_load_pending), 64'h1C00);
    ms_flush = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111_1111;
    #1;
    chk("flush_allowin", 64'(ms_allowin), 64'd0);
    chk("flush_valid", 64'(ms_to_ws_valid), 64'd0);
    tick();
    ms_flush = 1'b0;
    data_sram_data_ok = 1'b0;
    #1;
    chk("postflush_pending", 64'(ms_load_pending), 64'd0);
    chk("postflush_allowin", 64'(ms_allowin), 64'd1);
    push_exp(32'h1c00_0320, 5'd13, 1'b0, 32'h1313_1313, -1);
    enq(32'h1c00_0320, 32'h0000_4000, 5'd13, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    chk("newload_pending", 64'(ms_load_pending), 64'h2000);
    rsp_dropped(32'hDEAD_0001, "drop1");
    rsp_dropped(32'hDEAD_0002, "drop2");
    chk("after_drops_pending", 64'(ms_load_pending), 64'h2000);
    rsp(32'h1313_1313);
    tick(); tick();

    // Full queue held by WB, then retire, response and enqueue overlap
    ws_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp(32'h1c00_0400 + 32'(4 * i), 5'(1 + i), 1'b0, 32'h0000_0100 + 32'(i), -1);
      enq(32'h1c00_0400 + 32'(4 * i), 32'h0000_0100 + 32'(i), 5'(1 + i), 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    end
    push_exp(32'h1c00_040c, 5'd9, 1'b0, 32'h55AA_55AA, -1);
    enq(32'h1c00_040c, 32'h0000_5000, 5'd9, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    chk("held_allowin", 64'(ms_allowin), 64'd0);
    chk("held_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("held_pending", 64'(ms_load_pending), 64'h200);
    push_exp(32'h1c00_0410, 5'd4, 1'b0, 32'h0000_0104, -1);
    es_pc = 32'h1c00_0410; es_alu_result = 32'h0000_0104; es_gr_we = 1'b1; es_dest = 5'd4;
    es_mem_req = 1'b0; es_load_op = 1'b0; es_ex = 1'b0; es_to_ms_valid = 1'b1;
    ws_allowin = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h55AA_55AA;
    #1;
    chk("overlap_allowin_full", 64'(ms_allowin), 64'd0);
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    chk("overlap_allowin_after_retire", 64'(ms_allowin), 64'd1);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("overlap_allowin_steady", 64'(ms_allowin), 64'd1);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("overlap_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of operation
    ws_allowin = 1'b0;
    enq(32'h1c00_0500, 32'h0000_0777, 5'd7, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    chk("prereset_valid", 64'(ms_to_ws_valid), 64'd1);
    resetn = 1'b0;
    #1;
    chk("midreset_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("midreset_pc", 64'(ms_pc), 64'd0);
    tick(); tick();
    resetn = 1'b1;
    ws_allowin = 1'b1;
    #1;
    chk("afterreset_allowin", 64'(ms_allowin), 64'd1);
    chk("afterreset_valid", 64'(ms_to_ws_valid), 64'd0);
    push_exp(32'h1c00_0600, 5'd20, 1'b0, 32'hCAFE_F00D, cyc + 1);
    enq(32'h1c00_0600, 32'hCAFE_F00D, 5'd20, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
